// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, packer FSM states and block type.
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_BLK_BYTES = 16;

  // Byte value of a whole padding block (16 bytes of PKCS#7 pad).
  localparam logic [7:0] PAD_FULL_BYTE = 8'h10;

  typedef enum logic [0:0] {FILL, PAD} packer_state_t;

  typedef logic [AES_BLK_W-1:0] aes_block_t;

endpackage

// File: rtl/pkcs7_pad.sv
// Combinational block padder: keeps the first i_bytes bytes (MSB first) and
// overwrites the rest with the pad byte (16-i_bytes with AES_PACKER_PKCS7_EN, else 0x00).
module pkcs7_pad
  import aes_pkg::*;
(
  input  aes_block_t  i_blk,
  input  logic [4:0]  i_bytes,
  output aes_block_t  o_blk
);

  logic [7:0] w_pad;

`ifdef AES_PACKER_PKCS7_EN
  assign w_pad = 8'(AES_BLK_BYTES) - {3'b000, i_bytes};
`else
  assign w_pad = 8'h00;
`endif

  always_comb begin
    // NOTE: assign the whole output before the loop so no bit is left unassigned (no latch).
    o_blk = i_blk;
    for (int j = 0; j < AES_BLK_BYTES; j++) begin
      if (j >= int'(i_bytes)) o_blk[AES_BLK_W-1-8*j -: 8] = w_pad;
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a WORD_W-bit message stream into padded 128-bit AES plaintext blocks.
// Optional macro AES_PACKER_PKCS7_EN selects PKCS#7 padding (else zero padding).
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   s_data,
  input  logic [WORD_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output aes_block_t          blk_data,
  output logic                blk_valid,
  input  logic                blk_full,
  output logic                blk_last,
  output logic [15:0]         blk_count
);

  localparam int WORDS  = AES_BLK_W / WORD_W;
  localparam int CNT_W  = $clog2(WORDS);
  localparam int KEEP_W = WORD_W / 8;

  packer_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_word_cnt;
  aes_block_t       r_asm;
  aes_block_t       r_blk_data;
  logic             r_blk_valid;
  logic             r_blk_last;
  logic [15:0]      r_blk_count;

  logic             w_slot_free;
  logic             w_accept;
  logic             w_xfer;
  logic             w_word_last;
  logic [4:0]       w_bytes;
  aes_block_t       w_merged;
  aes_block_t       w_padded;
  logic             w_load;
  logic             w_load_last;
  aes_block_t       w_load_data;

  assign w_slot_free = ~r_blk_valid | ~blk_full;
  // Gated by rst_n so the upstream sees no ready while reset is asserted.
  assign s_ready     = rst_n & (r_state == FILL) & w_slot_free;
  assign w_accept    = s_valid & s_ready;
  assign w_xfer      = r_blk_valid & ~blk_full;
  assign w_word_last = (r_word_cnt == CNT_W'(WORDS - 1));

  // Bytes of message in the block being completed; a non-final word is always full.
  assign w_bytes = s_last ? 5'(r_word_cnt) * 5'(KEEP_W) + 5'($countones(s_keep))
                          : 5'(AES_BLK_BYTES);

  always_comb begin
    w_merged = r_asm;
    w_merged[AES_BLK_W-1-int'(r_word_cnt)*WORD_W -: WORD_W] = s_data;
  end

  pkcs7_pad u_pad (
    .i_blk   (w_merged),
    .i_bytes (w_bytes),
    .o_blk   (w_padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_load_data = w_padded;
    case (r_state)
      FILL: begin
        if (w_accept && (w_word_last || s_last)) begin
          w_load = 1'b1;
`ifdef AES_PACKER_PKCS7_EN
          // A full final block is not the last one: a whole pad block follows.
          w_load_last = s_last & (w_bytes != 5'(AES_BLK_BYTES));
          if (s_last && (w_bytes == 5'(AES_BLK_BYTES))) w_state_nxt = PAD;
`else
          w_load_last = s_last;
`endif
        end
      end
      PAD: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_last = 1'b1;
          w_load_data = {AES_BLK_BYTES{PAD_FULL_BYTE}};
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the assembly buffer is reset too, so a reset mid-block leaves no stale bytes.
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_asm       <= '0;
      r_blk_data  <= '0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_blk_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (w_accept) begin
        r_asm      <= w_merged;
        r_word_cnt <= w_load ? '0 : r_word_cnt + 1'b1;
      end
      if (w_load) begin
        r_blk_data  <= w_load_data;
        r_blk_valid <= 1'b1;
        r_blk_last  <= w_load_last;
      end else if (w_xfer) begin
        r_blk_valid <= 1'b0;
      end
      if (w_xfer) r_blk_count <= r_blk_count + 16'd1;
    end
  end

  assign blk_data  = r_blk_data;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer (WORD_W=32); expectations follow AES_PACKER_PKCS7_EN.
module tb_aes_block_packer;
  import aes_pkg::*;

`ifdef AES_PACKER_PKCS7_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  aes_block_t  blk_data;
  logic        blk_valid;
  logic        blk_full;
  logic        blk_last;
  logic [15:0] blk_count;

  always #5 clk = ~clk;

  aes_block_packer #(.WORD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_full  (blk_full),
    .blk_last  (blk_last),
    .blk_count (blk_count)
  );

  typedef struct packed {
    aes_block_t data;
    logic       last;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_count = '0;
  bit          saw_ffff = 1'b0;
  bit          saw_wrap = 1'b0;

  localparam aes_block_t PAD_BLK = {16{8'h10}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input aes_block_t d, input logic l);
    q.push_back({d, l});
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) check("s_ready_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (q.size() != 0 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: a transfer happens on the posedge following a negedge with valid & ~full.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && blk_valid && !blk_full) begin
        if (q.size() == 0) begin
          check("unexpected_blk", blk_valid, 0);
        end else begin
          mon_e = q.pop_front();
          check("blk_data", blk_data, mon_e.data);
          check("blk_last", blk_last, mon_e.last);
        end
        check("blk_count", blk_count, exp_count);
        if (saw_ffff && blk_count == 16'h0000) saw_wrap = 1'b1;
        saw_ffff  = (blk_count == 16'hFFFF);
        exp_count = exp_count + 16'd1;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aes_block_t full_blk;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; blk_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready",   s_ready,   0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_data",  blk_data,  0);
    check("rst_blk_last",  blk_last,  0);
    check("rst_blk_count", blk_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full 4-word message; the first word carries keep=0 (ignored without s_last).
    full_blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    push(full_blk, !PKCS);
    if (PKCS) push(PAD_BLK, 1'b1);
    send_word(32'h00112233, 4'h0, 1'b0);
    send_word(32'h44556677, 4'hF, 1'b0);
    send_word(32'h8899AABB, 4'hF, 1'b0);
    send_word(32'hCCDDEEFF, 4'hF, 1'b1);
    check("lat_valid", blk_valid, 1);
    check("lat_data",  blk_data,  full_blk);
    drain();
    check("t1_count", blk_count, PKCS ? 2 : 1);

    // Partial final block (6 bytes), garbage in the masked bytes.
    push(PKCS ? 128'h01020304_AABB0A0A_0A0A0A0A_0A0A0A0A
              : 128'h01020304_AABB0000_00000000_00000000, 1'b1);
    send_word(32'h01020304, 4'hF, 1'b0);
    send_word(32'hAABB5A5A, 4'hC, 1'b1);
    // s_last with keep=0 contributes no bytes.
    push(PKCS ? 128'h01020304_0C0C0C0C_0C0C0C0C_0C0C0C0C
              : 128'h01020304_00000000_00000000_00000000, 1'b1);
    send_word(32'h01020304, 4'hF, 1'b0);
    send_word(32'hFFFFFFFF, 4'h0, 1'b1);
    drain();
    check("t2_count", blk_count, PKCS ? 4 : 3);

    // Backpressure: block held for 5 cycles while a second word waits.
    blk_full = 1'b1;
    push(PKCS ? 128'hDEADBEEF_0C0C0C0C_0C0C0C0C_0C0C0C0C
              : 128'hDEADBEEF_00000000_00000000_00000000, 1'b1);
    push(PKCS ? 128'h110F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F
              : 128'h11000000_00000000_00000000_00000000, 1'b1);
    send_word(32'hDEADBEEF, 4'hF, 1'b1);
    fork
      send_word(32'h11223344, 4'h8, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", blk_valid, 1);
          check("bp_data",  blk_data, PKCS ? 128'hDEADBEEF_0C0C0C0C_0C0C0C0C_0C0C0C0C
                                           : 128'hDEADBEEF_00000000_00000000_00000000);
          check("bp_ready", s_ready, 0);
          check("bp_count", blk_count, PKCS ? 4 : 3);
        end
        @(posedge clk); #1;
        blk_full = 1'b0;
      end
    join
    drain();
    check("bp_count_after", blk_count, PKCS ? 6 : 5);

    // Reset mid-block: two words discarded, next four form a clean block.
    send_word(32'hDEAD0001, 4'hF, 1'b0);
    send_word(32'hDEAD0002, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_s_ready",   s_ready,   0);
    check("mrst_blk_valid", blk_valid, 0);
    check("mrst_blk_data",  blk_data,  0);
    check("mrst_blk_last",  blk_last,  0);
    check("mrst_blk_count", blk_count, 0);
    exp_count = '0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(128'hC0000000_C0000001_C0000002_C0000003, !PKCS);
    if (PKCS) push(PAD_BLK, 1'b1);
    send_word(32'hC0000000, 4'hF, 1'b0);
    send_word(32'hC0000001, 4'hF, 1'b0);
    send_word(32'hC0000002, 4'hF, 1'b0);
    send_word(32'hC0000003, 4'hF, 1'b1);
    drain();
    check("mrst_count_after", blk_count, PKCS ? 2 : 1);

    // Count wrap: 65536 single-word messages, one block per cycle back to back.
    for (int i = 0; i < 65536; i++) begin
      push({i[31:0], PKCS ? {12{8'h0C}} : 96'h0}, 1'b1);
      send_word(i[31:0], 4'hF, 1'b1);
    end
    drain();
    check("count_wrapped", saw_wrap, 1);
    check("count_final", blk_count, PKCS ? 2 : 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
